video_mode_sequencer: RTL
=========================

Name: video_mode_sequencer

Overview:
- Runtime controller for the sync/pattern video timing generator.
- Holds the timing configuration registers that feed the generator (H/V totals, porches, sync widths, interlace, HV offsets, ramp step) and the pixel-clock select.
- On a mode-change request it waits for a frame boundary, blanks the output, holds the generator in reset, loads the new mode, then releases.
- Sits between the host/OSD control logic and the sync_vg + pattern_vg pair.

Parameters:
- DEFAULT_MODE, 3'd2, mode loaded at reset (0=240p, 1=480p, 2=800x600, 3=720p, 4=1080i, 5=1080p).
- HOLD_CYCLES, 16, clocks the generator is held in reset after a register load (≥2).
- BLANK_FRAMES, 2, vsync rising edges counted with blank asserted after release (≥1).
- VS_TIMEOUT, 24'd4000000, clocks waited for a vsync edge before forcing the switch.

Ports:
- clk_in  input  1  control clock, all logic on posedge.
- resetb  input  1  asynchronous active-low reset.
- mode_sel  input  3  requested mode code.
- mode_req  input  1  single-cycle request strobe.
- vs_in  input  1  generator vsync, active high, asynchronous to clk_in.
- tg_resetb  output  1  active-low reset to the generator and pattern block.
- blank  output  1  forces RGB to 0 downstream.
- clk_sel  output  2  pixel clock select (0=27M, 1=40M, 2=74.25M, 3=148.5M).
- interlaced  output  1  generator interlace flag.
- cfg_h  output  48  {h_total, h_fp, h_bp, h_sync}, 12 bits each.
- cfg_v0  output  48  {v_total_0, v_fp_0, v_bp_0, v_sync_0}.
- cfg_v1  output  48  {v_total_1, v_fp_1, v_bp_1, v_sync_1}.
- hv_offset_1  output  12  field-1 HV offset (hv_offset_0 is always 0).
- ramp_step  output  20  pattern ramp step.
- cur_mode  output  3  mode currently loaded.
- busy  output  1  high in any state other than IDLE.
- mode_ack  output  1  one-cycle pulse on completion.
- mode_err  output  1  one-cycle pulse when a request names mode 6 or 7.

Behaviour:
- Reset:
  - All cfg outputs, clk_sel and cur_mode take DEFAULT_MODE values.
  - tg_resetb=0, blank=1, busy=1, mode_ack=0, mode_err=0.
  - State = HOLD with the counter cleared, so the first release is sequenced normally.
- vs_in passes through a 2-flop synchronizer plus an edge register. A rising edge is detected 3 clocks after the input rises.
- Mode ROM (combinational, registered on load):
  - 0: 1716/110/220/40; 262/5/20/5; prog; clk 0; step 0x333.
  - 1: 858/16/60/62; 525/9/30/6; prog; clk 0; step 0x333.
  - 2: 1056/40/88/128; 628/1/23/4; prog; clk 1; step 0x333.
  - 3: 1650/110/220/40; 750/5/20/5; prog; clk 2; step 0x333.
  - 4: 2200/88/148/44; 562/2/15/5 + 563/2/16/5; interlaced; hv_offset_1=1100; clk 2; step 0x222.
  - 5: 2200/88/148/44; 1125/4/36/5; prog; clk 3; step 0x222.
  - v1 fields and hv_offset_1 are 0 for progressive modes.
- States:
  - IDLE: on mode_req with mode_sel ≤5, latch it into tgt_mode and go to WAIT_VS. On mode_sel 6/7, pulse mode_err next cycle, stay in IDLE, leave the config untouched.
  - WAIT_VS: set blank=1 and count clocks. On a synced vsync rising edge or a count of VS_TIMEOUT-1, go to HOLD.
  - HOLD:
    - Entry cycle: tg_resetb=0, then load all cfg/clk_sel/cur_mode from the ROM (tgt_mode) one cycle later.
    - Count HOLD_CYCLES, then go to RELEASE.
  - RELEASE: tg_resetb=1, blank stays 1. Count BLANK_FRAMES synced vsync edges, then go to DONE.
  - DONE: blank=0, one-cycle mode_ack=1, go to IDLE. Post-reset completion also pulses mode_ack.
- Requests while busy:
  - Held in a one-deep pending register; a later request overwrites an earlier one (last wins).
  - A pending request is accepted in the cycle after DONE.
  - An invalid pending code pulses mode_err in the cycle after DONE and leaves the block in IDLE.
- A mode_req in the same cycle as DONE goes to pending.
- cfg outputs change only in the HOLD load cycle. They are stable whenever tg_resetb=1.
- vs_in stuck low: the timeout guarantees progress from WAIT_VS. RELEASE has no timeout (the generator is then running by construction).
- resetb asserted mid-sequence: immediate return to the reset state. Pending and target are cleared, and DEFAULT_MODE is reloaded.

Optional Feature:
- VMS_SKIP_SAME_EN
- Defined: a valid request whose code equals cur_mode, accepted in IDLE, pulses mode_ack on the next cycle. busy stays 0, and tg_resetb/blank are untouched.
- Undefined: every valid request runs the full WAIT_VS→HOLD→RELEASE→DONE sequence.

Test Plan:
- Reset release with DEFAULT_MODE=2 → cfg_h={1056,40,88,128}, clk_sel=1, tg_resetb rises 16 clocks after reset; mode_ack pulses after the 2nd vsync edge, then blank=0.
- mode_req with mode_sel=3, vsync every 5000 clocks → tg_resetb low within 4 clocks of the synced edge; cfg_h={1650,110,220,40}, clk_sel=2; ack after 2 further edges.
- mode_sel=4 → interlaced=1, cfg_v1={563,2,16,5}, hv_offset_1=1100, ramp_step=0x222.
- mode_sel=7 in IDLE → mode_err pulses for 1 cycle; cur_mode, busy and cfg unchanged.
- vs_in held low, VS_TIMEOUT=100, request mode 1 → HOLD entered at clock 100; final cur_mode=1.
- Requests 3 then 5 while busy, then resetb pulsed mid-HOLD → pending cleared; config returns to mode 2; no switch to 5 occurs.

Source files
------------

// File: rtl/video_mode_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : video_mode_sequencer                                             |
// | Purpose  : Runtime controller for the sync/pattern video timing generator.  |
// |            Owns the timing configuration registers and the pixel-clock      |
// |            select, and sequences mode changes:                              |
// |            wait for frame boundary -> blank -> hold generator in reset ->   |
// |            load new mode -> release -> blank for a few frames -> ack.       |
// | Ports    : clk_in, resetb (async, active low)                               |
// |            mode_sel/mode_req  : host mode request                           |
// |            vs_in              : generator vsync (asynchronous)              |
// |            tg_resetb, blank   : generator reset / downstream RGB blank      |
// |            clk_sel, interlaced, cfg_h, cfg_v0, cfg_v1, hv_offset_1,         |
// |            ramp_step          : generator configuration                     |
// |            cur_mode, busy, mode_ack, mode_err : status                      |
// | Options  : VMS_SKIP_SAME_EN - a valid request for the mode already loaded   |
// |            is acknowledged immediately without re-sequencing.               |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module video_mode_sequencer #(
   parameter logic [2:0]  DEFAULT_MODE = 3'd2,
   parameter int unsigned HOLD_CYCLES  = 16,
   parameter int unsigned BLANK_FRAMES = 2,
   parameter logic [23:0] VS_TIMEOUT   = 24'd4000000
) (
   input  logic        clk_in,
   input  logic        resetb,
   input  logic [2:0]  mode_sel,
   input  logic        mode_req,
   input  logic        vs_in,
   output logic        tg_resetb,
   output logic        blank,
   output logic [1:0]  clk_sel,
   output logic        interlaced,
   output logic [47:0] cfg_h,
   output logic [47:0] cfg_v0,
   output logic [47:0] cfg_v1,
   output logic [11:0] hv_offset_1,
   output logic [19:0] ramp_step,
   output logic [2:0]  cur_mode,
   output logic        busy,
   output logic        mode_ack,
   output logic        mode_err
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WAIT_VS = 3'd1,
      ST_HOLD    = 3'd2,
      ST_RELEASE = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   typedef struct packed {
      logic [47:0] h;
      logic [47:0] v0;
      logic [47:0] v1;
      logic [11:0] hvo;
      logic [19:0] step;
      logic [1:0]  clk;
      logic        il;
   } mode_cfg_t;

   // Mode table. Codes 6/7 never reach a load (rejected at request time);
   // they fall into the default arm so the ROM is fully specified.
   function automatic mode_cfg_t mode_rom(input logic [2:0] m);
      mode_cfg_t c;
      c      = '0;
      c.step = 20'h333;
      case (m)
         3'd0: begin
            c.h   = {12'd1716, 12'd110, 12'd220, 12'd40};
            c.v0  = {12'd262,  12'd5,   12'd20,  12'd5};
            c.clk = 2'd0;
         end
         3'd1: begin
            c.h   = {12'd858,  12'd16,  12'd60,  12'd62};
            c.v0  = {12'd525,  12'd9,   12'd30,  12'd6};
            c.clk = 2'd0;
         end
         3'd3: begin
            c.h   = {12'd1650, 12'd110, 12'd220, 12'd40};
            c.v0  = {12'd750,  12'd5,   12'd20,  12'd5};
            c.clk = 2'd2;
         end
         3'd4: begin
            c.h    = {12'd2200, 12'd88, 12'd148, 12'd44};
            c.v0   = {12'd562,  12'd2,  12'd15,  12'd5};
            c.v1   = {12'd563,  12'd2,  12'd16,  12'd5};
            c.hvo  = 12'd1100;
            c.il   = 1'b1;
            c.clk  = 2'd2;
            c.step = 20'h222;
         end
         3'd5: begin
            c.h    = {12'd2200, 12'd88, 12'd148, 12'd44};
            c.v0   = {12'd1125, 12'd4,  12'd36,  12'd5};
            c.clk  = 2'd3;
            c.step = 20'h222;
         end
         default: begin
            c.h   = {12'd1056, 12'd40,  12'd88,  12'd128};
            c.v0  = {12'd628,  12'd1,   12'd23,  12'd4};
            c.clk = 2'd1;
         end
      endcase
      return c;
   endfunction

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   state_t      state_q,     state_d;
   logic [23:0] cnt_q,       cnt_d;
   logic [2:0]  tgt_mode_q,  tgt_mode_d;
   logic        pend_vld_q,  pend_vld_d;
   logic [2:0]  pend_mode_q, pend_mode_d;
   logic        err_q,       err_d;
   logic        skip_ack_q,  skip_ack_d;
   mode_cfg_t   cfg_q,       cfg_d;
   logic [2:0]  cur_mode_q,  cur_mode_d;
   logic        vs_meta_q,   vs_meta_d;
   logic        vs_sync_q,   vs_sync_d;
   logic        vs_prev_q,   vs_prev_d;

   logic        vs_rise;
   logic        load;
   logic        req_vld;
   logic [2:0]  req_code;

   // vsync crosses from the pixel domain: two sync flops plus one history
   // flop, so a rising input is acted on at the third clock edge.
   always_comb begin
      vs_meta_d = vs_in;
      vs_sync_d = vs_meta_q;
      vs_prev_d = vs_sync_q;
   end

   assign vs_rise = vs_sync_q & ~vs_prev_q;

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      tgt_mode_d  = tgt_mode_q;
      pend_vld_d  = pend_vld_q;
      pend_mode_d = pend_mode_q;
      err_d       = 1'b0;
      skip_ack_d  = 1'b0;
      load        = 1'b0;
      req_vld     = 1'b0;
      req_code    = mode_sel;

      // In IDLE a live strobe wins over a pending one (last request wins);
      // outside IDLE every strobe just overwrites the pending slot.
      if (state_q == ST_IDLE) begin
         pend_vld_d = 1'b0;
         if (mode_req) begin
            req_vld  = 1'b1;
            req_code = mode_sel;
         end else if (pend_vld_q) begin
            req_vld  = 1'b1;
            req_code = pend_mode_q;
         end
      end else if (mode_req) begin
         pend_vld_d  = 1'b1;
         pend_mode_d = mode_sel;
      end

      case (state_q)
         ST_IDLE: begin
            if (req_vld) begin
               if (req_code > 3'd5) begin
                  err_d = 1'b1;
               end else begin
`ifdef VMS_SKIP_SAME_EN
                  if (req_code == cur_mode_q) begin
                     skip_ack_d = 1'b1;
                  end else begin
                     tgt_mode_d = req_code;
                     cnt_d      = '0;
                     state_d    = ST_WAIT_VS;
                  end
`else
                  tgt_mode_d = req_code;
                  cnt_d      = '0;
                  state_d    = ST_WAIT_VS;
`endif
               end
            end
         end

         ST_WAIT_VS: begin
            // Timeout keeps a dead vsync from stalling the switch forever.
            if (vs_rise || (cnt_q == VS_TIMEOUT - 24'd1)) begin
               cnt_d   = '0;
               state_d = ST_HOLD;
            end else begin
               cnt_d = cnt_q + 24'd1;
            end
         end

         ST_HOLD: begin
            // Generator is already in reset during the entry cycle; the new
            // configuration lands on the following edge.
            load = (cnt_q == '0);
            if (cnt_q == 24'(HOLD_CYCLES - 1)) begin
               cnt_d   = '0;
               state_d = ST_RELEASE;
            end else begin
               cnt_d = cnt_q + 24'd1;
            end
         end

         ST_RELEASE: begin
            if (vs_rise) begin
               if (cnt_q == 24'(BLANK_FRAMES - 1)) begin
                  cnt_d   = '0;
                  state_d = ST_DONE;
               end else begin
                  cnt_d = cnt_q + 24'd1;
               end
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      cfg_d      = load ? mode_rom(tgt_mode_q) : cfg_q;
      cur_mode_d = load ? tgt_mode_q : cur_mode_q;
   end

   // ---------------------------------------------------------------------------
   // State registers. Reset lands in HOLD so the power-up release follows the
   // same path as any other mode change.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_in or negedge resetb) begin
      if (!resetb) begin
         state_q     <= ST_HOLD;
         cnt_q       <= '0;
         tgt_mode_q  <= DEFAULT_MODE;
         pend_vld_q  <= 1'b0;
         pend_mode_q <= '0;
         err_q       <= 1'b0;
         skip_ack_q  <= 1'b0;
         cfg_q       <= mode_rom(DEFAULT_MODE);
         cur_mode_q  <= DEFAULT_MODE;
         vs_meta_q   <= 1'b0;
         vs_sync_q   <= 1'b0;
         vs_prev_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tgt_mode_q  <= tgt_mode_d;
         pend_vld_q  <= pend_vld_d;
         pend_mode_q <= pend_mode_d;
         err_q       <= err_d;
         skip_ack_q  <= skip_ack_d;
         cfg_q       <= cfg_d;
         cur_mode_q  <= cur_mode_d;
         vs_meta_q   <= vs_meta_d;
         vs_sync_q   <= vs_sync_d;
         vs_prev_q   <= vs_prev_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs (decoded from registered state only)
   // ---------------------------------------------------------------------------
   assign tg_resetb   = (state_q != ST_HOLD);
   assign blank       = (state_q == ST_WAIT_VS) || (state_q == ST_HOLD) ||
                        (state_q == ST_RELEASE);
   assign busy        = (state_q != ST_IDLE);
   assign mode_ack    = (state_q == ST_DONE) || skip_ack_q;
   assign mode_err    = err_q;

   assign cfg_h       = cfg_q.h;
   assign cfg_v0      = cfg_q.v0;
   assign cfg_v1      = cfg_q.v1;
   assign hv_offset_1 = cfg_q.hvo;
   assign ramp_step   = cfg_q.step;
   assign clk_sel     = cfg_q.clk;
   assign interlaced  = cfg_q.il;
   assign cur_mode    = cur_mode_q;

endmodule
`default_nettype wire
